memory_responder: RTL and testbench

Unified instruction/data memory that answers the 8-bit pipelined processor's memory interface. It serves the fetch port (program_counter -> instruction_code) and the data port (access_address/byte_enable/write_enable/data_write -> data_read). A valid/ready load port lets a testbench or boot controller write whole 32-bit words. After reset, a clear sequencer initialises every word before the block reports ready.

---
 rtl/memory_responder.sv | 95 +++++++++
 tb/tb_memory_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Unified instruction/data word memory with a fetch port, a byte-lane data port
// and a valid/ready word-load port; a clear sequence initialises storage after reset.
module memory_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] INIT_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  program_counter,
  output logic [31:0] instruction_code,
  input  logic [7:0]  access_address,
  input  logic [3:0]  byte_enable,
  input  logic        write_enable,
  input  logic [7:0]  data_write,
  output logic [31:0] data_read,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [5:0]  load_addr,
  input  logic [31:0] load_data,
  output logic        mem_ready,
  output logic        addr_err
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(DEPTH_WORDS - 1);

  state_t      state, state_next;
  logic [5:0]  clear_cnt;
  // Full 6-bit address space is declared; words at or above DEPTH_WORDS are never
  // written or read, so only DEPTH_WORDS entries survive synthesis.
  logic [31:0] mem [0:63];

  logic [5:0] fetch_idx, data_idx;
  logic       fetch_ok, data_ok, load_ok, load_fire;

  assign fetch_idx = program_counter[7:2];
  assign data_idx  = access_address[7:2];
  assign fetch_ok  = ({26'd0, fetch_idx} < DEPTH_WORDS);
  assign data_ok   = ({26'd0, data_idx} < DEPTH_WORDS);
  assign load_ok   = ({26'd0, load_addr} < DEPTH_WORDS);
  assign load_fire = load_valid & load_ready;

  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    load_ready = 1'b0;
    case (state)
      CLEAR: begin
        if (clear_cnt == LAST_IDX) state_next = RUN;
      end
      RUN: begin
        mem_ready  = 1'b1;
        // A data write in the same cycle always wins over the loader.
        load_ready = !(write_enable && (|byte_enable));
      end
      default: state_next = CLEAR;
    endcase
  end

  assign instruction_code = (mem_ready && fetch_ok) ? mem[fetch_idx] : 32'd0;
  assign data_read        = (mem_ready && data_ok)  ? mem[data_idx]  : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_cnt <= 6'd0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == CLEAR && state_next == CLEAR) clear_cnt <= clear_cnt + 6'd1;
      else                                       clear_cnt <= 6'd0;
      if (mem_ready && (!fetch_ok || !data_ok || (write_enable && !data_ok) ||
                        (load_fire && !load_ok)))
        addr_err <= 1'b1;
    end
  end

  // Storage has no reset; only the clear sequence and the two write ports touch it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clear_cnt] <= INIT_WORD;
      end else begin
        if (write_enable && data_ok) begin
          for (int n = 0; n < 4; n++) begin
            if (byte_enable[n]) mem[data_idx][8*n +: 8] <= data_write;
          end
        end
        if (load_fire && load_ok) mem[load_addr] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: clear timing, load port, byte writes,
// write/load arbitration, out-of-range detection and mid-run reset.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  program_counter, access_address, data_write;
  logic [3:0]  byte_enable;
  logic        write_enable, load_valid;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] instruction_code, data_read;
  logic        load_ready, mem_ready, addr_err;

  logic [7:0]  pc16;
  logic [31:0] instr16, dread16;
  logic        lready16, mready16, err16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH_WORDS(64), .INIT_WORD(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .program_counter(program_counter), .instruction_code(instruction_code),
    .access_address(access_address), .byte_enable(byte_enable),
    .write_enable(write_enable), .data_write(data_write), .data_read(data_read),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .mem_ready(mem_ready), .addr_err(addr_err)
  );

  memory_responder #(.DEPTH_WORDS(16), .INIT_WORD(32'hCAFE_0000)) dut16 (
    .clk(clk), .reset(reset),
    .program_counter(pc16), .instruction_code(instr16),
    .access_address(8'h00), .byte_enable(4'b0000),
    .write_enable(1'b0), .data_write(8'h00), .data_read(dread16),
    .load_valid(1'b0), .load_ready(lready16), .load_addr(6'd0),
    .load_data(32'd0), .mem_ready(mready16), .addr_err(err16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; program_counter = 8'h00; access_address = 8'h00;
    byte_enable = 4'b0; write_enable = 1'b0; data_write = 8'h00;
    load_valid = 1'b0; load_addr = 6'd0; load_data = 32'd0; pc16 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Clear lasts exactly 64 cycles with outputs forced to zero.
    for (int i = 0; i < 64; i++) begin
      check("clear_mem_ready", {31'd0, mem_ready}, 32'd0);
      check("clear_instr", instruction_code, 32'd0);
      check("clear_load_ready", {31'd0, load_ready}, 32'd0);
      step();
    end
    check("run_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("run_addr_err", {31'd0, addr_err}, 32'd0);
    check("dut16_ready", {31'd0, mready16}, 32'd1);
    check("dut16_init", instr16, 32'hCAFE_0000);
    check("dut16_err_init", {31'd0, err16}, 32'd0);

    for (int i = 0; i < 64; i++) begin
      program_counter = 8'(i * 4);
      access_address  = 8'(i * 4 + 3);
      #1;
      check("init_fetch", instruction_code, 32'hDEAD_BEEF);
      check("init_data", data_read, 32'hDEAD_BEEF);
    end
    step();

    // Load word 5 and read it on both ports.
    load_valid = 1'b1; load_addr = 6'd5; load_data = 32'h1234_5678;
    #1;
    check("load_ready_idle", {31'd0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    program_counter = 8'h14; access_address = 8'h16;
    #1;
    check("load_fetch", instruction_code, 32'h1234_5678);
    check("load_data", data_read, 32'h1234_5678);

    // Byte write to lane 2: old value until the edge.
    write_enable = 1'b1; byte_enable = 4'b0100; data_write = 8'hAA; access_address = 8'h15;
    #1;
    check("rdw_old", data_read, 32'h1234_5678);
    check("rdw_old_fetch", instruction_code, 32'h1234_5678);
    check("load_ready_wr", {31'd0, load_ready}, 32'd0);
    step();
    write_enable = 1'b0;
    #1;
    check("lane2_data", data_read, 32'h12AA_5678);
    check("lane2_fetch", instruction_code, 32'h12AA_5678);

    // Multi-lane replicated write, then an empty-enable write.
    write_enable = 1'b1; byte_enable = 4'b1001; data_write = 8'h5A;
    step();
    check("lanes03", data_read, 32'h5AAA_565A);
    byte_enable = 4'b0000; data_write = 8'hFF;
    #1;
    check("load_ready_be0", {31'd0, load_ready}, 32'd1);
    step();
    write_enable = 1'b0;
    #1;
    check("be0_nowrite", data_read, 32'h5AAA_565A);

    // Held load to word 3 loses to two data writes, then wins.
    load_valid = 1'b1; load_addr = 6'd3; load_data = 32'hCAFE_F00D;
    write_enable = 1'b1; byte_enable = 4'b0001; data_write = 8'h11; access_address = 8'h0C;
    #1;
    check("arb_ready_c1", {31'd0, load_ready}, 32'd0);
    step();
    check("arb_ready_c2", {31'd0, load_ready}, 32'd0);
    check("arb_wr_word3", data_read, 32'hDEAD_BE11);
    step();
    write_enable = 1'b0;
    #1;
    check("arb_ready_c3", {31'd0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    #1;
    check("arb_load_word3", data_read, 32'hCAFE_F00D);
    check("arb_word5_kept", instruction_code, 32'h5AAA_565A);

    // Out-of-range fetch on the 16-word instance.
    pc16 = 8'h40;
    #1;
    check("oor_fetch", instr16, 32'd0);
    check("oor_err_before_edge", {31'd0, err16}, 32'd0);
    step();
    pc16 = 8'h00;
    check("oor_err_set", {31'd0, err16}, 32'd1);
    step(); step();
    check("oor_err_sticky", {31'd0, err16}, 32'd1);
    check("dut64_err_clear", {31'd0, addr_err}, 32'd0);

    // Reset, then a load burst during CLEAR, then a mid-clear reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("oor_err_reset", {31'd0, err16}, 32'd0);
    load_valid = 1'b1; load_addr = 6'd7; load_data = 32'h7777_7777;
    for (int i = 0; i < 30; i++) step();
    check("midclear_ready", {31'd0, load_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      check("reclear_load_ready", {31'd0, load_ready}, 32'd0);
      step();
    end
    check("reclear_done", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      program_counter = 8'(i * 4 + 1);
      access_address  = 8'(i * 4 + 2);
      #1;
      check("reinit_fetch", instruction_code, 32'hDEAD_BEEF);
      check("reinit_data", data_read, 32'hDEAD_BEEF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
